// File: rtl/eleven_bit_serial_subtractor.sv
// Bit-serial 11-bit subtractor, LSB first, one bit per clock.
// Start/Busy/Done handshake; borrow, overflow and zero flags.
module eleven_bit_serial_subtractor #(
   parameter int WIDTH = 11
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Start,
   input  logic [WIDTH-1:0] SRC1,
   input  logic [WIDTH-1:0] SRC2,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Output,
   output logic             Borrow,
   output logic             Overflow,
   output logic             Zero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] sr;
   logic [CW-1:0]    cnt;
   logic             br;
   logic             sa;
   logic             sb;

   logic             d;
   logic             brn;
   logic [WIDTH-1:0] nxt;

   always_comb begin
      d   = a[0] ^ b[0] ^ br;
      brn = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & br);
      nxt = {d, sr[WIDTH-1:1]};
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         a        <= '0;
         b        <= '0;
         sr       <= '0;
         cnt      <= '0;
         br       <= 1'b0;
         sa       <= 1'b0;
         sb       <= 1'b0;
         Busy     <= 1'b0;
         Done     <= 1'b0;
         Output   <= '0;
         Borrow   <= 1'b0;
         Overflow <= 1'b0;
         Zero     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (Start) begin
                  a     <= SRC1;
                  b     <= SRC2;
                  sa    <= SRC1[WIDTH-1];
                  sb    <= SRC2[WIDTH-1];
                  sr    <= '0;
                  br    <= 1'b0;
                  cnt   <= '0;
                  Busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               sr  <= nxt;
               a   <= a >> 1;
               b   <= b >> 1;
               br  <= brn;
               cnt <= cnt + 1'b1;
               // last bit: publish result and flags together
               if (cnt == LAST) begin
                  Output   <= nxt;
                  Borrow   <= brn;
                  Overflow <= (sa != sb) && (d != sa);
                  Zero     <= (nxt == '0);
                  Done     <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               Done  <= 1'b0;
               Busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eleven_bit_serial_subtractor.sv
// Scoreboard bench for the serial subtractor: a cycle model
// predicts acceptance, results come from plain integer arithmetic.
module tb_eleven_bit_serial_subtractor;

   typedef struct {
      logic [10:0] r;
      logic        b;
      logic        v;
      logic        z;
      int          acc;
   } exp_t;

   logic        CLK;
   logic        RST;
   logic        Start;
   logic [10:0] SRC1;
   logic [10:0] SRC2;
   logic        Busy;
   logic        Done;
   logic [10:0] Output;
   logic        Borrow;
   logic        Overflow;
   logic        Zero;

   eleven_bit_serial_subtractor dut (
      .CLK     (CLK),
      .RST     (RST),
      .Start   (Start),
      .SRC1    (SRC1),
      .SRC2    (SRC2),
      .Busy    (Busy),
      .Done    (Done),
      .Output  (Output),
      .Borrow  (Borrow),
      .Overflow(Overflow),
      .Zero    (Zero)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int   nvec = 0;
   int   nbad = 0;
   int   mcnt = 0;
   int   ecount = 0;
   exp_t q[$];
   exp_t held;

   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nbad++;
         $display("FAIL %s: got %0d, expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic exp_t ref_sub(input logic [10:0] x,
                                    input logic [10:0] y,
                                    input int acc);
      exp_t e;
      int ux, uy, sx, sy, diff;
      ux = int'(x);
      uy = int'(y);
      sx = (ux >= 1024) ? ux - 2048 : ux;
      sy = (uy >= 1024) ? uy - 2048 : uy;
      diff = sx - sy;
      e.r = 11'((ux - uy) & 'h7FF);
      e.b = (ux < uy);
      e.v = (diff > 1023) || (diff < -1024);
      e.z = (e.r == 11'd0);
      e.acc = acc;
      return e;
   endfunction

   // Timing model: 13-cycle occupancy per accepted Start
   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         mcnt <= 0;
      end else begin
         ecount <= ecount + 1;
         if (mcnt == 0) begin
            if (Start) begin
               q.push_back(ref_sub(SRC1, SRC2, ecount + 1));
               mcnt <= 12;
            end
         end else begin
            mcnt <= mcnt - 1;
         end
      end
   end

   // Monitor: handshake every cycle, results on each Done
   always @(negedge CLK) begin
      if (RST) begin
         q.delete();
         held = '{11'd0, 1'b0, 1'b0, 1'b0, 0};
      end
      chk("busy", int'(Busy), int'(mcnt != 0));
      chk("done", int'(Done), int'(mcnt == 1));
      if (Done) begin
         if (q.size() == 0) begin
            chk("done_without_start", 1, 0);
         end else begin
            held = q.pop_front();
            chk("latency", ecount - held.acc, 11);
         end
      end
      chk("output", int'(Output), int'(held.r));
      chk("borrow", int'(Borrow), int'(held.b));
      chk("overflow", int'(Overflow), int'(held.v));
      chk("zero", int'(Zero), int'(held.z));
   end

   task automatic do_op(input logic [10:0] x, input logic [10:0] y);
      @(negedge CLK);
      SRC1  = x;
      SRC2  = y;
      Start = 1'b1;
      @(negedge CLK);
      Start = 1'b0;
      SRC1  = 11'($urandom);
      SRC2  = 11'($urandom);
      repeat (13) @(negedge CLK);
   endtask

   initial begin
      RST   = 1'b0;
      Start = 1'b0;
      SRC1  = '0;
      SRC2  = '0;
      #1 RST = 1'b1;
      #1;
      chk("rst_busy", int'(Busy), 0);
      chk("rst_done", int'(Done), 0);
      chk("rst_output", int'(Output), 0);
      chk("rst_flags", int'({Borrow, Overflow, Zero}), 0);
      @(negedge CLK);
      @(posedge CLK);
      #2 RST = 1'b0;

      do_op(11'd885, 11'd1250);
      do_op(11'd1000, 11'd1000);
      do_op(11'd0, 11'd1);
      do_op(11'h400, 11'd1);
      do_op(11'h7FF, 11'h400);
      do_op(11'h3FF, 11'h7FF);

      for (int i = 0; i < 20; i++)
         do_op(11'($urandom), 11'($urandom));

      // Start held high, operands changing every cycle
      @(negedge CLK);
      Start = 1'b1;
      for (int i = 0; i < 66; i++) begin
         SRC1 = 11'($urandom);
         SRC2 = 11'($urandom);
         @(negedge CLK);
      end
      Start = 1'b0;
      repeat (15) @(negedge CLK);

      // Abort mid-operation with an asynchronous reset
      SRC1  = 11'd885;
      SRC2  = 11'd1250;
      Start = 1'b1;
      @(negedge CLK);
      Start = 1'b0;
      repeat (5) @(negedge CLK);
      #2 RST = 1'b1;
      #1;
      chk("abort_busy", int'(Busy), 0);
      chk("abort_done", int'(Done), 0);
      chk("abort_output", int'(Output), 0);
      chk("abort_flags", int'({Borrow, Overflow, Zero}), 0);
      @(negedge CLK);
      @(posedge CLK);
      #2 RST = 1'b0;

      do_op(11'd5, 11'd3);
      repeat (3) @(negedge CLK);
      chk("queue_drained", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
